host_line_xfer: RTL and testbench

//  Line-transfer engine directly downstream of mem_system's cache controller. Accepts one 512-bit

---
 rtl/mem_xfer_pkg.sv | 24 ++
 rtl/host_line_xfer_if.sv | 34 +++
 rtl/line_beat_buf.sv | 55 +++++
 rtl/host_line_xfer.sv | 137 +++++++++++++
 tb/tb_host_line_xfer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_xfer_pkg.sv
// Shared types for the cache-line transfer engine; the cache controller imports the same op encoding.
package mem_xfer_pkg;

   localparam int LINE_W_DEF = 512;
   localparam int BEAT_W_DEF = 64;
   localparam int ADDR_W_DEF = 32;

   typedef enum logic [1:0] {
      OP_NONE  = 2'b00,
      OP_READ  = 2'b01,
      OP_WRITE = 2'b10,
      OP_RSVD  = 2'b11
   } op_host_t;

   typedef enum logic [2:0] {
      XS_IDLE,
      XS_REQ,
      XS_WDATA,
      XS_WRESP,
      XS_RDATA,
      XS_RESP
   } xfer_state_t;

endpackage

// File: rtl/host_line_xfer_if.sv
// Host-side request / write-beat / read-beat bus; master is the transfer engine.
interface host_line_xfer_if
   import mem_xfer_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int BEAT_W = BEAT_W_DEF
);
   logic              host_req_valid;
   logic              host_req_ready;
   logic [ADDR_W-1:0] host_req_addr;
   logic              host_req_wr;
   logic              host_wvalid;
   logic              host_wready;
   logic [BEAT_W-1:0] host_wdata;
   logic              host_wlast;
   logic              host_wresp;
   logic              host_rvalid;
   logic [BEAT_W-1:0] host_rdata;
   logic              host_rlast;

   modport master (
      output host_req_valid, host_req_addr, host_req_wr,
      output host_wvalid, host_wdata, host_wlast,
      input  host_req_ready, host_wready, host_wresp,
      input  host_rvalid, host_rdata, host_rlast
   );

   modport slave (
      input  host_req_valid, host_req_addr, host_req_wr,
      input  host_wvalid, host_wdata, host_wlast,
      output host_req_ready, host_wready, host_wresp,
      output host_rvalid, host_rdata, host_rlast
   );
endinterface

// File: rtl/line_beat_buf.sv
// One cache line with a beat index: muxes out the indexed beat for writes and demuxes read beats in.
// Zero latency on beat_out; idx advances one per shift_out/capture_in, no internal backpressure.
module line_beat_buf #(
   parameter  int LINE_W = 512,
   parameter  int BEAT_W = 64,
   localparam int BEATS  = LINE_W / BEAT_W,
   localparam int IDX_W  = $clog2(BEATS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_line,
   input  logic              clr_idx,
   input  logic [LINE_W-1:0] line_in,
   input  logic              shift_out,
   input  logic              capture_in,
   input  logic [BEAT_W-1:0] beat_in,
   output logic [BEAT_W-1:0] beat_out,
   output logic [LINE_W-1:0] line_out,
   output logic [IDX_W-1:0]  idx,
   output logic              last
);
   logic [LINE_W-1:0] line_q, line_d;
   logic [IDX_W-1:0]  idx_q, idx_d;

   always_comb begin
      line_d = line_q;
      idx_d  = idx_q;
      if (load_line) begin
         line_d = line_in;
         idx_d  = '0;
      end else if (clr_idx) begin
         idx_d = '0;
      end else if (capture_in) begin
         line_d[idx_q*BEAT_W +: BEAT_W] = beat_in;
         idx_d = idx_q + IDX_W'(1);
      end else if (shift_out) begin
         idx_d = idx_q + IDX_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_q <= '0;
         idx_q  <= '0;
      end else begin
         line_q <= line_d;
         idx_q  <= idx_d;
      end
   end

   assign beat_out = line_q[idx_q*BEAT_W +: BEAT_W];
   assign line_out = line_q;
   assign idx      = idx_q;
   assign last     = (idx_q == IDX_W'(BEATS - 1));
endmodule

// File: rtl/host_line_xfer.sv
// Moves one cache line per op_host command as BEAT_W beats: read = 1+BEATS+1 cycles, write = 1+BEATS+wresp+1.
// Stalls on host_req_ready/host_wready/host_wresp; read beats are always accepted in RDATA.
module host_line_xfer
   import mem_xfer_pkg::*;
#(
   parameter int LINE_W = LINE_W_DEF,
   parameter int BEAT_W = BEAT_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        op_host,
   input  logic [ADDR_W-1:0] AddrOut_host,
   input  logic [LINE_W-1:0] DataOut_host,
   output logic [LINE_W-1:0] DataIn_host,
   output logic              rd_valid_host,
   output logic              tx_done_host,
   output logic              xfer_err,
   host_line_xfer_if.master  host
);
   localparam int BEATS = LINE_W / BEAT_W;
   localparam int OFF_W = $clog2(LINE_W / 8);
   localparam int IDX_W = $clog2(BEATS);
   localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'((1 << OFF_W) - 1);

   xfer_state_t       state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              wr_q, wr_d;
   logic              err_q, err_d;
   logic [LINE_W-1:0] din_q, din_d;

   logic              load_line, clr_idx, shift_out, capture_in;
   logic [BEAT_W-1:0] beat_out;
   logic [LINE_W-1:0] line_out;
   logic [IDX_W-1:0]  beat_idx;
   logic              beat_last;

   line_beat_buf #(.LINE_W(LINE_W), .BEAT_W(BEAT_W)) u_buf (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_line  (load_line),
      .clr_idx    (clr_idx),
      .line_in    (DataOut_host),
      .shift_out  (shift_out),
      .capture_in (capture_in),
      .beat_in    (host.host_rdata),
      .beat_out   (beat_out),
      .line_out   (line_out),
      .idx        (beat_idx),
      .last       (beat_last)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      wr_d       = wr_q;
      err_d      = err_q;
      din_d      = din_q;
      load_line  = 1'b0;
      clr_idx    = 1'b0;
      shift_out  = 1'b0;
      capture_in = 1'b0;
      case (state_q)
         XS_IDLE: begin
            case (op_host_t'(op_host))
               OP_READ: begin
                  addr_d  = AddrOut_host & ADDR_MASK;
                  wr_d    = 1'b0;
                  clr_idx = 1'b1;
                  state_d = XS_REQ;
               end
               OP_WRITE: begin
                  addr_d    = AddrOut_host & ADDR_MASK;
                  wr_d      = 1'b1;
                  load_line = 1'b1;
                  state_d   = XS_REQ;
               end
               default: ;
            endcase
         end
         XS_REQ: begin
            if (host.host_req_ready) state_d = wr_q ? XS_WDATA : XS_RDATA;
         end
         XS_WDATA: begin
            if (host.host_wready) begin
               shift_out = 1'b1;
               if (beat_last) state_d = XS_WRESP;
            end
         end
         XS_WRESP: begin
            if (host.host_wresp) state_d = XS_RESP;
         end
         XS_RDATA: begin
            // beat count decides completion; a misplaced rlast only flags the error
            if (host.host_rvalid) begin
               capture_in = 1'b1;
               if (host.host_rlast != (beat_idx == IDX_W'(BEATS - 1))) err_d = 1'b1;
               if (beat_last) state_d = XS_RESP;
            end
         end
         XS_RESP: begin
            if (!wr_q) din_d = line_out;
            state_d = XS_IDLE;
         end
         default: state_d = XS_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= XS_IDLE;
         addr_q  <= '0;
         wr_q    <= 1'b0;
         err_q   <= 1'b0;
         din_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wr_q    <= wr_d;
         err_q   <= err_d;
         din_q   <= din_d;
      end
   end

   // the fresh read line is visible during RESP, then held in din_q across later writes
   assign DataIn_host   = (state_q == XS_RESP && !wr_q) ? line_out : din_q;
   assign rd_valid_host = (state_q == XS_RESP) && !wr_q;
   assign tx_done_host  = (state_q == XS_RESP);
   assign xfer_err      = err_q;

   assign host.host_req_valid = (state_q == XS_REQ);
   assign host.host_req_addr  = addr_q;
   assign host.host_req_wr    = wr_q;
   assign host.host_wvalid    = (state_q == XS_WDATA);
   assign host.host_wdata     = beat_out;
   assign host.host_wlast     = (state_q == XS_WDATA) && beat_last;
endmodule

// File: tb/tb_host_line_xfer.sv
// Directed + randomized bench for host_line_xfer with a beat-list reference model of the line transfer.
module tb_host_line_xfer;
   import mem_xfer_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [1:0]   op_host;
   logic [31:0]  AddrOut_host;
   logic [511:0] DataOut_host;
   logic [511:0] DataIn_host;
   logic         rd_valid_host, tx_done_host, xfer_err;

   host_line_xfer_if hif ();

   host_line_xfer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .op_host       (op_host),
      .AddrOut_host  (AddrOut_host),
      .DataOut_host  (DataOut_host),
      .DataIn_host   (DataIn_host),
      .rd_valid_host (rd_valid_host),
      .tx_done_host  (tx_done_host),
      .xfer_err      (xfer_err),
      .host          (hif)
   );

   always #5 clk = ~clk;

   int           n_pass = 0;
   int           n_total = 0;
   bit           err_model = 1'b0;
   logic [511:0] prev_line = '0;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic chk_i(input string tag, input int obs, input int exp);
      n_total++;
      assert (obs == exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic drive_host_idle();
      hif.host_req_ready = 1'b0;
      hif.host_wready    = 1'b0;
      hif.host_wresp     = 1'b0;
      hif.host_rvalid    = 1'b0;
      hif.host_rdata     = '0;
      hif.host_rlast     = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_req_valid"}, 512'(hif.host_req_valid), 0);
      chk({tag, "_req_addr"},  512'(hif.host_req_addr), 0);
      chk({tag, "_req_wr"},    512'(hif.host_req_wr), 0);
      chk({tag, "_wvalid"},    512'(hif.host_wvalid), 0);
      chk({tag, "_wdata"},     512'(hif.host_wdata), 0);
      chk({tag, "_wlast"},     512'(hif.host_wlast), 0);
      chk({tag, "_tx_done"},   512'(tx_done_host), 0);
      chk({tag, "_rd_valid"},  512'(rd_valid_host), 0);
      chk({tag, "_xfer_err"},  512'(xfer_err), 0);
      chk({tag, "_datain"},    DataIn_host, 0);
   endtask

   function automatic logic [511:0] rand_line();
      logic [511:0] r;
      for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // One cycle of NONE after a completion; the engine must be idle with no pulses.
   task automatic idle_gap();
      op_host = 2'b00;
      @(posedge clk);
      @(negedge clk);
      chk("gap_tx_done", 512'(tx_done_host), 0);
      chk("gap_rd_valid", 512'(rd_valid_host), 0);
      chk("gap_req_valid", 512'(hif.host_req_valid), 0);
   endtask

   // Called at a negedge; returns at the negedge of the completion cycle.
   task automatic do_read(input logic [31:0] addr, input int rlast_pos, input int req_stall,
                          input int gap_pct, input bit chained, input bit fixed);
      logic [63:0]  beats [8];
      logic [511:0] exp_line;
      int           b = 0, cyc = 0, first_req = -1, last_cyc = -100, stall_left = req_stall;
      bit           accepted = 1'b0, done = 1'b0;
      for (int i = 0; i < 8; i++) begin
         beats[i] = fixed ? 64'(i + 1) * 64'h11 : {$urandom, $urandom};
         exp_line[i*64 +: 64] = beats[i];
      end
      op_host      = 2'b01;
      AddrOut_host = addr;
      DataOut_host = rand_line();
      while (!done && cyc < 400) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         drive_host_idle();
         if (tx_done_host) begin
            if (rlast_pos != 7) err_model = 1'b1;
            chk_i("rd_done_cycle", cyc, last_cyc + 1);
            chk_i("rd_beats", b, 8);
            chk("rd_valid", 512'(rd_valid_host), 1);
            chk("rd_line", DataIn_host, exp_line);
            chk("rd_xfer_err", 512'(xfer_err), 512'(err_model));
            prev_line = exp_line;
            done = 1'b1;
         end else if (hif.host_req_valid) begin
            if (first_req < 0) begin
               first_req = cyc;
               chk_i("rd_req_cycle", cyc, chained ? 2 : 1);
               chk("rd_req_wr", 512'(hif.host_req_wr), 0);
               chk("rd_hold_line", DataIn_host, prev_line);
            end
            chk("rd_req_addr", 512'(hif.host_req_addr), 512'(addr & ~32'h3f));
            if (stall_left > 0) begin
               stall_left--;
               hif.host_rvalid = 1'b1;
               hif.host_rdata  = {$urandom, $urandom};
               hif.host_rlast  = 1'b1;
               hif.host_wresp  = 1'b1;
            end else begin
               hif.host_req_ready = 1'b1;
               accepted = 1'b1;
            end
         end else if (accepted && b < 8) begin
            if (int'($urandom_range(99)) >= gap_pct) begin
               hif.host_rvalid = 1'b1;
               hif.host_rdata  = beats[b];
               hif.host_rlast  = (b == rlast_pos);
               last_cyc = cyc;
               b++;
            end
         end
      end
      if (!done) chk("rd_timeout", 0, 1);
   endtask

   // Called at a negedge; returns at the completion negedge, or right after reset when aborted.
   task automatic do_write(input logic [31:0] addr, input logic [511:0] line, input int req_stall,
                           input int wr_mode, input int wresp_dly, input int abort_at);
      int cyc = 0, b = 0, first_req = -1, wait_cnt = 0, wresp_cyc = -100, stall_left = req_stall;
      bit accepted = 1'b0, done = 1'b0, resp_sent = 1'b0;
      op_host      = 2'b10;
      AddrOut_host = addr;
      DataOut_host = line;
      while (!done && cyc < 400) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         drive_host_idle();
         if (tx_done_host) begin
            chk_i("wr_done_cycle", cyc, wresp_cyc + 1);
            chk_i("wr_beats", b, 8);
            chk("wr_rd_valid", 512'(rd_valid_host), 0);
            chk("wr_datain_kept", DataIn_host, prev_line);
            chk("wr_xfer_err", 512'(xfer_err), 512'(err_model));
            done = 1'b1;
         end else if (hif.host_req_valid) begin
            if (first_req < 0) begin
               first_req = cyc;
               chk_i("wr_req_cycle", cyc, 1);
               chk("wr_req_wr", 512'(hif.host_req_wr), 1);
            end
            chk("wr_req_addr", 512'(hif.host_req_addr), 512'(addr & ~32'h3f));
            if (stall_left > 0) begin
               stall_left--;
               hif.host_wresp  = 1'b1;
               hif.host_rvalid = 1'b1;
            end else begin
               hif.host_req_ready = 1'b1;
               accepted = 1'b1;
            end
         end else if (hif.host_wvalid) begin
            if (b >= 8) begin
               chk("wr_extra_beat", 1, 0);
            end else if (abort_at >= 0 && b == abort_at) begin
               rst_n = 1'b0;
               #1;
               chk_zero("abort");
               return;
            end else begin
               chk("wr_wdata", 512'(hif.host_wdata), 512'(line[b*64 +: 64]));
               chk("wr_wlast", 512'(hif.host_wlast), 512'(b == 7));
               case (wr_mode)
                  0:       hif.host_wready = 1'b1;
                  1:       hif.host_wready = cyc[0];
                  default: hif.host_wready = $urandom_range(1) == 1;
               endcase
               if (hif.host_wready) b++;
            end
         end else if (accepted && b == 8 && !resp_sent) begin
            if (wait_cnt == wresp_dly) begin
               hif.host_wresp = 1'b1;
               resp_sent = 1'b1;
               wresp_cyc = cyc;
            end else begin
               wait_cnt++;
            end
         end
      end
      if (!done) chk("wr_timeout", 0, 1);
   endtask

   initial begin
      logic [511:0] k_line;
      rst_n        = 1'b0;
      op_host      = 2'b00;
      AddrOut_host = '0;
      DataOut_host = '0;
      drive_host_idle();
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // fill with known beats, always-ready host
      do_read(32'h0000_1234, 7, 0, 0, 1'b0, 1'b1);
      chk("t1_low_beat", 512'(DataIn_host[63:0]), 512'(64'h11));
      chk("t1_high_beat", 512'(DataIn_host[511:448]), 512'(64'h88));
      idle_gap();

      for (int k = 0; k < 8; k++) k_line[k*64 +: 64] = 64'(k) * 64'h0101;
      do_write(32'h8000_0047, k_line, 0, 0, 2, -1);
      idle_gap();

      // request stall plus alternating write-beat backpressure
      do_write($urandom, rand_line(), 5, 1, 0, -1);
      idle_gap();

      // writeback then fill issued on the completion edge
      do_write($urandom, rand_line(), 0, 0, 1, -1);
      do_read($urandom, 7, 0, 0, 1'b1, 1'b0);
      idle_gap();

      // early rlast flags an error that stays set
      do_read($urandom, 3, 0, 0, 1'b0, 1'b0);
      idle_gap();
      do_read($urandom, 7, 2, 20, 1'b0, 1'b0);
      idle_gap();

      for (int t = 0; t < 6; t++) begin
         if ($urandom_range(1) == 1)
            do_read($urandom, 7, int'($urandom_range(3)), 30, 1'b0, 1'b0);
         else
            do_write($urandom, rand_line(), int'($urandom_range(3)), 2, int'($urandom_range(4)), -1);
         idle_gap();
      end

      // reset in the middle of the write burst
      do_write($urandom, rand_line(), 0, 0, 0, 4);
      drive_host_idle();
      op_host = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      err_model = 1'b0;
      prev_line = '0;
      @(negedge clk);
      chk_zero("post_reset");
      do_read($urandom, 7, 0, 0, 1'b0, 1'b0);
      idle_gap();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
